// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port lookup ROM between two burst-read requesters.
// Grant in IDLE, one ACCESS cycle per beat, then RESP holds until the owner's resp_ready.
module rom_read_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4,
  parameter int ROM_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*LEN_W-1:0]    req_len,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic                  rom_ce,
  output logic                  rom_read_en,
  input  logic [DATA_W-1:0]     rom_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(ROM_DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic                r_rr_ptr;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;

  logic                w_grant_vld;
  logic                w_grant_id;
  logic                w_in_range;
  logic                w_last;
  logic [ADDR_W-1:0]   w_grant_addr;
  logic [LEN_W-1:0]    w_grant_len;
  logic [ADDR_W-1:0]   w_next_addr;

  always_comb begin
    w_grant_vld  = |req_valid;
    w_grant_id   = (&req_valid) ? r_rr_ptr : req_valid[1];
    w_grant_addr = w_grant_id ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    w_grant_len  = w_grant_id ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];
    w_in_range   = (r_cur_addr < DEPTH_A);
    w_last       = (r_remaining == '0);
    w_next_addr  = (r_cur_addr >= DEPTH_A - 1'b1) ? '0 : r_cur_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // rst_n gates req_ready so a requester held valid through reset never sees a false accept.
  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    rom_ce      = 1'b0;
    rom_read_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld && rst_n) begin
          req_ready[w_grant_id] = 1'b1;
          w_next                = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rom_ce      = w_in_range;
        rom_read_en = w_in_range;
        w_next      = S_RESP;
      end
      S_RESP: begin
        resp_valid[r_owner] = 1'b1;
        if (resp_ready[r_owner]) w_next = w_last ? S_IDLE : S_ACCESS;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_owner     <= w_grant_id;
            r_cur_addr  <= w_grant_addr;
            r_remaining <= w_grant_len;
          end
        end
        S_ACCESS: begin
          r_data <= w_in_range ? rom_data : '0;
          r_err  <= ~w_in_range;
        end
        S_RESP: begin
          if (resp_ready[r_owner]) begin
            if (w_last) begin
              r_rr_ptr <= ~r_owner;
            end else begin
              r_remaining <= r_remaining - 1'b1;
              r_cur_addr  <= w_next_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // cur_addr only moves on entry to ACCESS, so it doubles as the held ROM address.
  assign rom_addr  = r_cur_addr;
  assign resp_data = r_data;
  assign resp_err  = r_err;
  assign resp_last = (r_state == S_RESP) && w_last;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural case-decoded ROM.
// Inputs driven and outputs sampled at posedge+1/+2, away from the active edge.
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_len;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [7:0]  resp_data;
  logic        resp_last;
  logic        resp_err;
  logic [7:0]  rom_addr;
  logic        rom_ce;
  logic        rom_read_en;
  logic [7:0]  rom_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    case (a)
      8'd0:  rom_f = 8'h0A;  8'd1:  rom_f = 8'h37;  8'd2:  rom_f = 8'hF4;  8'd3:  rom_f = 8'h11;
      8'd4:  rom_f = 8'h22;  8'd5:  rom_f = 8'hFF;  8'd6:  rom_f = 8'h33;  8'd7:  rom_f = 8'h44;
      8'd8:  rom_f = 8'h55;  8'd9:  rom_f = 8'h66;  8'd10: rom_f = 8'h77;  8'd11: rom_f = 8'h15;
      8'd12: rom_f = 8'h88;  8'd13: rom_f = 8'h90;  8'd14: rom_f = 8'h70;  8'd15: rom_f = 8'h90;
      default: rom_f = 8'hEE;
    endcase
  endfunction

  assign rom_data = rom_f(rom_addr);

  rom_read_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_data(rom_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; resp_ready = 2'b11;
    req_addr = {8'd7, 8'd3}; req_len = 8'h00;
    repeat (3) tick();
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
    checks++; if ({rom_ce, rom_read_en, rom_addr} !== 10'd0) begin errors++; $display("FAIL reset_rom got ce=%b re=%b addr=%0d exp 0", rom_ce, rom_read_en, rom_addr); end
    checks++; if ({resp_data, resp_last, resp_err} !== 10'd0) begin errors++; $display("FAIL reset_resp got data=%h last=%b err=%b exp 0", resp_data, resp_last, resp_err); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b exp 01", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if (rom_addr !== 8'd3) begin errors++; $display("FAIL reset_first_addr got %0d exp 3", rom_addr); end
    tick(); #1;
    checks++; if (resp_valid !== 2'b01 || resp_data !== 8'h11) begin errors++; $display("FAIL reset_first_resp got v=%b d=%h exp v=01 d=11", resp_valid, resp_data); end
    tick();
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_addr = {8'd0, 8'd2}; req_len = 8'h00;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    tick(); req_valid = 2'b00; #1;
    checks++; if ({rom_ce, rom_read_en} !== 2'b11 || rom_addr !== 8'd2) begin errors++; $display("FAIL single_access got ce=%b re=%b addr=%0d exp 1 1 2", rom_ce, rom_read_en, rom_addr); end
    checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL single_access_idle got v=%b r=%b exp 00 00", resp_valid, req_ready); end
    tick(); #1;
    checks++; if (resp_valid !== 2'b01 || resp_data !== 8'hF4 || resp_last !== 1'b1 || resp_err !== 1'b0)
      begin errors++; $display("FAIL single_resp got v=%b d=%h l=%b e=%b exp 01 f4 1 0", resp_valid, resp_data, resp_last, resp_err); end
    tick(); #1;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_done got %b exp 00", resp_valid); end
  endtask

  task automatic test_wrap_burst();
    logic [7:0] exp_a [4] = '{8'd14, 8'd15, 8'd0, 8'd1};
    logic [7:0] exp_d [4] = '{8'h70, 8'h90, 8'h0A, 8'h37};
    req_valid = 2'b10; req_addr = {8'd14, 8'd0}; req_len = {4'd3, 4'd0};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wrap_ready got %b exp 10", req_ready); end
    tick(); req_valid = 2'b00;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++; if (rom_ce !== 1'b1 || rom_addr !== exp_a[b]) begin errors++; $display("FAIL wrap_access%0d got ce=%b addr=%0d exp 1 %0d", b, rom_ce, rom_addr, exp_a[b]); end
      tick(); #1;
      checks++; if (resp_valid !== 2'b10 || resp_data !== exp_d[b] || resp_last !== (b == 3) || resp_err !== 1'b0)
        begin errors++; $display("FAIL wrap_beat%0d got v=%b d=%h l=%b e=%b exp 10 %h %b 0", b, resp_valid, resp_data, resp_last, resp_err, exp_d[b], (b == 3)); end
      tick();
    end
    #1;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL wrap_done got %b exp 00", resp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    req_valid = 2'b11; req_addr = {8'd11, 8'd5}; req_len = 8'h00;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (g % 2 == 0) ? 8'hFF : 8'h15;
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", g, req_ready, exp_g); end
      tick(); #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cont_busy%0d got %b exp 00", g, req_ready); end
      tick(); #1;
      checks++; if (resp_valid !== exp_g || resp_data !== exp_d) begin errors++; $display("FAIL cont_resp%0d got v=%b d=%h exp %b %h", g, resp_valid, resp_data, exp_g, exp_d); end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    resp_ready = 2'b00;
    req_valid = 2'b01; req_addr = {8'd0, 8'd13}; req_len = 8'h00;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready got %b exp 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    for (int c = 0; c < 5; c++) begin
      resp_ready = (c >= 3) ? 2'b10 : 2'b00;
      #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 8'h90 || resp_last !== 1'b1 || rom_ce !== 1'b0 || rom_addr !== 8'd13)
        begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b ce=%b a=%0d exp 01 90 1 0 13", c, resp_valid, resp_data, resp_last, rom_ce, rom_addr); end
      tick();
    end
    resp_ready = 2'b01;
    tick(); #1;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL bp_release got %b exp 00", resp_valid); end
    resp_ready = 2'b11;
  endtask

  task automatic test_out_of_range();
    req_valid = 2'b01; req_addr = {8'd0, 8'd20}; req_len = {4'd0, 4'd1};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL oor_ready got %b exp 01", req_ready); end
    tick(); req_valid = 2'b00; #1;
    checks++; if ({rom_ce, rom_read_en} !== 2'b00) begin errors++; $display("FAIL oor_access got ce=%b re=%b exp 0 0", rom_ce, rom_read_en); end
    tick(); #1;
    checks++; if (resp_valid !== 2'b01 || resp_data !== 8'h00 || resp_err !== 1'b1 || resp_last !== 1'b0)
      begin errors++; $display("FAIL oor_beat0 got v=%b d=%h e=%b l=%b exp 01 00 1 0", resp_valid, resp_data, resp_err, resp_last); end
    tick(); #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 8'd0) begin errors++; $display("FAIL oor_wrap got ce=%b addr=%0d exp 1 0", rom_ce, rom_addr); end
    tick(); #1;
    checks++; if (resp_valid !== 2'b01 || resp_data !== 8'h0A || resp_err !== 1'b0 || resp_last !== 1'b1)
      begin errors++; $display("FAIL oor_beat1 got v=%b d=%h e=%b l=%b exp 01 0a 0 1", resp_valid, resp_data, resp_err, resp_last); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 2'b01; req_addr = {8'd0, 8'd3}; req_len = {4'd0, 4'd3};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_ready got %b exp 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); tick(); tick(); #1;
    checks++; if (resp_valid !== 2'b01 || resp_data !== 8'h22) begin errors++; $display("FAIL rmid_beat1 got v=%b d=%h exp 01 22", resp_valid, resp_data); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (resp_valid !== 2'b00 || rom_ce !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d got v=%b ce=%b exp 00 0", c, resp_valid, rom_ce); end
      tick();
    end
    req_valid = 2'b10; req_addr = {8'd9, 8'd0}; req_len = 8'h00;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rmid_regrant got %b exp 10", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); #1;
    checks++; if (resp_valid !== 2'b10 || resp_data !== 8'h66 || resp_last !== 1'b1) begin errors++; $display("FAIL rmid_resp got v=%b d=%h l=%b exp 10 66 1", resp_valid, resp_data, resp_last); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_burst();
    test_contention();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
